uart_tx_fifo: RTL and testbench

- Transmit-side byte buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from the CPU's memory-mapped UART write path, stores them in a circular FIFO, and feeds them one at a time to the transmitter.
- Handshake toward the transmitter: one-cycle valid strobe out, one-cycle done pulse back.
- Lets software queue a burst of characters without polling for line idle between each byte.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 tb/tb_uart_tx_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART-wide shared definitions: byte width and the TX buffer's FSM state encoding.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    TXF_IDLE = 2'd0,
    TXF_WAIT = 2'd1,
    TXF_GAP  = 2'd2
  } txf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular register FIFO with count-derived full/empty; shared by the TX and RX buffers.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = UART_BYTE_W
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Push,
  input  logic [WIDTH-1:0]  i_Push_Data,
  input  logic              i_Pop,
  output logic [WIDTH-1:0]  o_Pop_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count
);

  logic [WIDTH-1:0]  r_Mem [DEPTH];
  logic [ADDR_W-1:0] r_Wr_Ptr;
  logic [ADDR_W-1:0] r_Rd_Ptr;
  logic [ADDR_W:0]   r_Count;
  logic              w_Push_Ok;
  logic              w_Pop_Ok;

  assign o_Full     = (r_Count == (ADDR_W+1)'(DEPTH));
  assign o_Empty    = (r_Count == '0);
  assign o_Count    = r_Count;
  assign o_Pop_Data = r_Mem[r_Rd_Ptr];

  // Full/empty tests use the pre-cycle count, so a push at full is dropped even alongside a pop.
  assign w_Push_Ok = i_Push && !o_Full;
  assign w_Pop_Ok  = i_Pop && !o_Empty;

  always_ff @(posedge i_Clock) begin
    if (w_Push_Ok) r_Mem[r_Wr_Ptr] <= i_Push_Data;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Push_Ok) r_Wr_Ptr <= r_Wr_Ptr + ADDR_W'(1);
      if (w_Pop_Ok)  r_Rd_Ptr <= r_Rd_Ptr + ADDR_W'(1);
      case ({w_Push_Ok, w_Pop_Ok})
        2'b10:   r_Count <= r_Count + (ADDR_W+1)'(1);
        2'b01:   r_Count <= r_Count - (ADDR_W+1)'(1);
        default: r_Count <= r_Count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// TX byte buffer: queues CPU writes and hands them to the transmitter one at a time.
// States: TXF_IDLE wait for data | TXF_WAIT byte in flight | TXF_GAP post-done cleanup gap
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Wr_En,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  input  logic                   i_Clr_Ovf,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Overflow,
  output logic                   o_Busy,
  output logic                   o_Tx_DV,
  output logic [UART_BYTE_W-1:0] o_Tx_Byte,
  input  logic                   i_Tx_Done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  txf_state_t             r_State;
  txf_state_t             w_State_Next;
  logic [GAP_W-1:0]       r_Gap_Cnt;
  logic                   r_Tx_DV;
  logic [UART_BYTE_W-1:0] r_Tx_Byte;
  logic                   r_Overflow;
  logic                   w_Pop;
  logic                   w_Gap_Load;
  logic                   w_Gap_Dec;
  logic [UART_BYTE_W-1:0] w_Head;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (UART_BYTE_W)
  ) u_fifo (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Push      (i_Wr_En),
    .i_Push_Data (i_Wr_Byte),
    .i_Pop       (w_Pop),
    .o_Pop_Data  (w_Head),
    .o_Full      (o_Full),
    .o_Empty     (o_Empty),
    .o_Count     (o_Count)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) r_State <= TXF_IDLE;
    else         r_State <= w_State_Next;
  end

  always_comb begin
    w_State_Next = r_State;
    w_Pop        = 1'b0;
    w_Gap_Load   = 1'b0;
    w_Gap_Dec    = 1'b0;
    case (r_State)
      TXF_IDLE: begin
        if (!o_Empty) begin
          w_Pop        = 1'b1;
          w_State_Next = TXF_WAIT;
        end
      end
      TXF_WAIT: begin
        if (i_Tx_Done) begin
          w_Gap_Load   = 1'b1;
          w_State_Next = TXF_GAP;
        end
      end
      TXF_GAP: begin
        if (r_Gap_Cnt == '0) w_State_Next = TXF_IDLE;
        else                 w_Gap_Dec    = 1'b1;
      end
      default: w_State_Next = TXF_IDLE;
    endcase
  end

  // Down-counter: TXF_GAP lasts exactly GAP_CYCLES cycles after the done pulse.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)         r_Gap_Cnt <= '0;
    else if (w_Gap_Load) r_Gap_Cnt <= GAP_W'(GAP_CYCLES - 1);
    else if (w_Gap_Dec)  r_Gap_Cnt <= r_Gap_Cnt - GAP_W'(1);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Tx_DV   <= 1'b0;
      r_Tx_Byte <= '0;
    end else begin
      r_Tx_DV <= w_Pop;
      if (w_Pop) r_Tx_Byte <= w_Head;
    end
  end

  // Set beats clear when a dropped write and i_Clr_Ovf coincide.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)                r_Overflow <= 1'b0;
    else if (i_Wr_En && o_Full) r_Overflow <= 1'b1;
    else if (i_Clr_Ovf)         r_Overflow <= 1'b0;
  end

  assign o_Tx_DV    = r_Tx_DV;
  assign o_Tx_Byte  = r_Tx_Byte;
  assign o_Overflow = r_Overflow;
  assign o_Busy     = !o_Empty || (r_State != TXF_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int GAP    = 3;

  logic          i_Clock   = 1'b0;
  logic          i_Reset   = 1'b1;
  logic          i_Wr_En   = 1'b0;
  logic [7:0]    i_Wr_Byte = 8'h00;
  logic          i_Clr_Ovf = 1'b0;
  logic          i_Tx_Done = 1'b0;
  logic          o_Full;
  logic          o_Empty;
  logic [ADDR_W:0] o_Count;
  logic          o_Overflow;
  logic          o_Busy;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;

  always #5 i_Clock = ~i_Clock;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Wr_En    (i_Wr_En),
    .i_Wr_Byte  (i_Wr_Byte),
    .i_Clr_Ovf  (i_Clr_Ovf),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow),
    .o_Busy     (o_Busy),
    .o_Tx_DV    (o_Tx_DV),
    .o_Tx_Byte  (o_Tx_Byte),
    .i_Tx_Done  (i_Tx_Done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: queue contents, one in-flight flag, earliest edge for the next strobe.
  int         q[$];
  bit         m_inflight = 0;
  int         m_ready    = 0;
  bit         m_ovf      = 0;
  int         m_dv_cyc   = 0;
  logic [7:0] m_byte     = 8'h00;
  bit         tx_auto    = 0;
  bit         rand_delay = 0;
  int         tx_delay   = 20;
  int         obs_bytes[$];
  int         obs_edges[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight = 0;
    m_ready    = 0;
    m_ovf      = 0;
    m_byte     = 8'h00;
  endtask

  task automatic tick(input bit wr, input logic [7:0] b, input bit clr, input bit stray);
    bit done;
    bit pop;
    int pre;
    done = stray || (tx_auto && m_inflight && (cyc + 1 == m_dv_cyc + tx_delay));
    i_Wr_En   = wr;
    i_Wr_Byte = b;
    i_Clr_Ovf = clr;
    i_Tx_Done = done;
    @(posedge i_Clock);
    cyc++;
    pre = q.size();
    pop = !m_inflight && (cyc >= m_ready) && (pre > 0);
    if (done && m_inflight) begin
      m_inflight = 0;
      m_ready    = cyc + GAP + 1;
    end
    if (pop) begin
      m_byte     = 8'(q.pop_front());
      m_inflight = 1;
      m_dv_cyc   = cyc;
      if (rand_delay) tx_delay = $urandom_range(1, 8);
    end
    if (wr && pre == DEPTH) m_ovf = 1;
    else if (clr)           m_ovf = 0;
    if (wr && pre < DEPTH) q.push_back(int'(b));
    #1;
    chk("count",    32'(o_Count),    32'(q.size()));
    chk("empty",    32'(o_Empty),    32'(q.size() == 0));
    chk("full",     32'(o_Full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(o_Overflow), 32'(m_ovf));
    chk("busy",     32'(o_Busy),     32'((q.size() != 0) || m_inflight || (cyc < m_ready - 1)));
    chk("tx_dv",    32'(o_Tx_DV),    32'(pop));
    chk("tx_byte",  32'(o_Tx_Byte),  32'(m_byte));
    if (o_Tx_DV === 1'b1) begin
      obs_bytes.push_back(int'(o_Tx_Byte));
      obs_edges.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    tx_auto  = 1;
    for (int k = 0; k < 3000; k++) begin
      if (o_Busy !== 1'b1) break;
      tick(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk(tag, 32'(o_Busy), 32'd0);
  endtask

  initial begin
    int n;
    int w10;
    model_reset();
    repeat (2) @(posedge i_Clock);
    #1;
    chk("rst_count", 32'(o_Count),    32'd0);
    chk("rst_empty", 32'(o_Empty),    32'd1);
    chk("rst_full",  32'(o_Full),     32'd0);
    chk("rst_busy",  32'(o_Busy),     32'd0);
    chk("rst_dv",    32'(o_Tx_DV),    32'd0);
    chk("rst_ovf",   32'(o_Overflow), 32'd0);
    chk("rst_byte",  32'(o_Tx_Byte),  32'd0);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    cyc = 0;

    // Single byte: write at edge 10, strobe at 11, done at 40, next strobe no earlier than 44.
    idle(9);
    tick(1'b1, 8'h41, 1'b0, 1'b0);
    w10 = cyc;
    idle(1);
    chk("single_dv_edge", 32'(obs_edges.size() > 0 ? obs_edges[0] : -1), 32'(w10 + 1));
    chk("single_busy",    32'(o_Busy), 32'd1);
    idle(28);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);
    chk("gap_busy",  32'(o_Busy), 32'd1);
    idle(2);
    chk("idle_busy", 32'(o_Busy), 32'd0);
    obs_bytes.delete();
    obs_edges.delete();

    // Burst of five with the transmitter answering 20 cycles after each strobe.
    tx_auto  = 1;
    tx_delay = 20;
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    idle(140);
    chk("burst_n", 32'(obs_bytes.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_bytes.size(); i++) begin
      chk("burst_byte", 32'(obs_bytes[i]), 32'(16 + i));
      if (i > 0) chk("burst_space", 32'(obs_edges[i] - obs_edges[i-1]), 32'(20 + GAP + 1));
    end
    obs_bytes.delete();
    obs_edges.delete();

    // Fill with the transmitter stalled, then overflow and clear.
    tx_auto = 0;
    for (int i = 0; i <= 16; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_first", 32'(obs_bytes.size() > 0 ? obs_bytes[0] : -1), 32'd0);
    chk("fill_count", 32'(o_Count), 32'd16);
    chk("fill_full",  32'(o_Full),  32'd1);
    tick(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set",   32'(o_Overflow), 32'd1);
    chk("ovf_count", 32'(o_Count),    32'd16);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_clr",   32'(o_Overflow), 32'd0);

    // Write at full in the same cycle as the pop that follows the gap.
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(GAP);
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    chk("simul_dv",    32'(o_Tx_DV),    32'd1);
    chk("simul_byte",  32'(o_Tx_Byte),  32'h01);
    chk("simul_count", 32'(o_Count),    32'd15);
    chk("simul_ovf",   32'(o_Overflow), 32'd1);
    tx_delay = 2;
    drain("drain1");
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    obs_bytes.delete();
    obs_edges.delete();

    // Pointer wrap: 40 sequential bytes with occupancy kept below full.
    tx_delay = 1;
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      if (n == 40 && o_Busy !== 1'b1) break;
      if (n < 40 && q.size() < 15) begin
        tick(1'b1, 8'(n), 1'b0, 1'b0);
        n++;
      end else begin
        tick(1'b0, 8'h00, 1'b0, 1'b0);
      end
    end
    chk("wrap_n", 32'(obs_bytes.size()), 32'd40);
    for (int i = 0; i < obs_bytes.size(); i++) chk("wrap_byte", 32'(obs_bytes[i]), 32'(i));

    // Random traffic: writes, clears, stray done pulses, varying transmitter latency.
    rand_delay = 1;
    for (int k = 0; k < 600; k++)
      tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0);
    drain("drain2");
    rand_delay = 0;

    // Asynchronous reset between edges with five queued and one in flight.
    tx_auto = 0;
    for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    idle(1);
    chk("pre_rst_count", 32'(o_Count), 32'd5);
    #2;
    i_Reset = 1'b1;
    #1;
    model_reset();
    chk("arst_empty", 32'(o_Empty),    32'd1);
    chk("arst_count", 32'(o_Count),    32'd0);
    chk("arst_dv",    32'(o_Tx_DV),    32'd0);
    chk("arst_busy",  32'(o_Busy),     32'd0);
    chk("arst_ovf",   32'(o_Overflow), 32'd0);
    @(posedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    obs_bytes.delete();
    obs_edges.delete();
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(6);
    chk("post_rst_no_dv", 32'(obs_bytes.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
